fp_match: RTL and testbench
===========================

# fp_match

Fingerprint search engine that sits directly downstream of the fingerprint store. It walks the store's search read ports and compares the stored template against the test print row by row, at every vertical offset in a configurable window. It accumulates a per-offset ridge-overlap score and reports the best score, the offset that produced it, and a match decision against a runtime threshold.

## Interface
Parameters:
- ROWS, 256: rows per print; also the store depth.
- WIDTH, 256: bits per row.
- OFFSET_MAX, 8: offsets searched are -OFFSET_MAX..+OFFSET_MAX.
- SW, $clog2(ROWS*WIDTH+1) = 17: score width.
- OW, $clog2(OFFSET_MAX+1)+1 = 5: signed offset width.

Ports (one clock; reset is synchronous and active-high):
- search_clk, in, 1: sole clock; the store's search port runs on the same clock.
- search_rst, in, 1: synchronous active-high reset.
- start, in, 1: begin a search; sampled only in IDLE.
- threshold, in, SW: match threshold; sampled at start.
- search_out_add, out, 8: template row address.
- search_out_add_test, out, 8: test row address.
- search_out_data, in, 2*WIDTH: [511:256] is the template row, [255:0] is the test row; valid 1 cycle after the address.
- busy, out, 1: search in progress.
- done, out, 1: 1-cycle pulse when the result is valid.
- best_score, out, SW: highest per-offset score.
- best_offset, out, OW: signed offset that gave best_score.
- match, out, 1: best_score >= threshold.

## Operation
- States:
  - IDLE: start goes to RUN.
  - RUN: issues addresses; after the last address goes to DRAIN.
  - DRAIN: 3 cycles to flush the pipeline.
  - DONE: 1 cycle, pulses done, then back to IDLE.
- Issue order: offset o from -OFFSET_MAX up to +OFFSET_MAX (outer loop); row r from 0 to ROWS-1 (inner loop). One address pair per cycle, with no bubbles.
- Addresses: search_out_add = r. The test row index is r+o, computed 9-bit signed.
  - If 0 <= r+o < ROWS: search_out_add_test = r+o.
  - Otherwise: search_out_add_test = 0 and an invalid flag travels down the pipeline with the row. That row contributes 0.
- Row score = popcount(template & test).
- acc clears at r = 0 of each offset and sums the row scores. At r = ROWS-1 its final value is compared against best_score.
- Best update only when the new score is strictly greater. Ties keep the earlier (more negative) offset.
- best_score starts at 0 and best_offset starts at -OFFSET_MAX on every start. An all-zero result therefore reports best_offset = -OFFSET_MAX.
- match is registered together with best_score, using the threshold latched at start.
- best_score, best_offset and match hold until the next start.
- start while not in IDLE is ignored.
- Reset, including mid-search: state goes to IDLE. busy, done, match, best_score, acc and both addresses go to 0; best_offset goes to -OFFSET_MAX. Pipeline valid flags clear, so no stale accumulation occurs after reset.

## Timing
- Reset values:
  - busy = 0, done = 0, match = 0, best_score = 0.
  - best_offset = -OFFSET_MAX.
  - search_out_add = 0, search_out_add_test = 0.
- Per-row pipeline:
  - Address driven (registered) in cycle n.
  - Store data valid in n+1.
  - Four 64-bit partial popcounts registered in n+2.
  - Partials summed into acc in n+3.
  - Best/match compare registered in n+4.
- start sampled high at cycle 0:
  - busy = 1 from cycle 1.
  - First address in cycle 1; last address in cycle L = (2*OFFSET_MAX+1)*ROWS.
  - done pulses in cycle L+4, and busy drops in that same cycle.
  - With defaults, start to done is 4356 cycles.
- A new start is accepted in the cycle after done.

## Configuration
- FP_MATCH_XNOR_EN:
  - Defined: row score = popcount(~(template ^ test)), counting equal bits, both ridge and valley.
  - Undefined: popcount(template & test), counting ridge overlap only.
- Out-of-range rows contribute 0 in both modes.

## Structure
- fp_match_pkg holds:
  - The state enum.
  - Default ROWS/WIDTH/OFFSET_MAX.
  - Score and offset width constants.
  - The data-field split constants for template and test halves.
- One sub-module, fp_popcount: a 2-stage pipelined WIDTH-bit popcount with a valid flag passed through.

## Test plan
Bench uses a behavioural store model with 1-cycle read latency.
- Both prints all-ones, threshold 40000 -> best_offset 0, best_score 65536, match 1, done exactly at cycle 4356.
- Both prints all-zero, threshold 1 -> best_score 0, best_offset -8, match 0.
- Template row 100 all-ones and test row 103 all-ones, everything else zero -> best_offset +3, best_score 256.
- Search from test 1, search_rst asserted at cycle 1000, then a fresh start -> outputs at reset values the next cycle, and the fresh search returns exactly test 1's result.
- start pulsed at cycles 0, 50 and 4000 -> only one done, at cycle 4356; the extra starts are ignored.
- With FP_MATCH_XNOR_EN, all-zero prints -> best_offset 0, best_score 65536.

Source files
------------

// File: rtl/fp_match_pkg.sv
// fp_match_pkg: shared types and constants for the fingerprint search engine.
// Optional feature macro: FP_MATCH_XNOR_EN (selects the equal-bit row score).
package fp_match_pkg;

  // Search controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default geometry
  localparam int ROWS_DEF       = 256;
  localparam int WIDTH_DEF      = 256;
  localparam int OFFSET_MAX_DEF = 8;

  // Score and signed-offset widths for the default geometry
  localparam int SW_DEF = $clog2(ROWS_DEF * WIDTH_DEF + 1);
  localparam int OW_DEF = $clog2(OFFSET_MAX_DEF + 1) + 1;

  // Store address width (store depth is at most 256 rows)
  localparam int AW = 8;

  // Field index of each half inside the store read word, in units of WIDTH
  localparam int TMPL_FIELD = 1;
  localparam int TEST_FIELD = 0;

  // Number of partial-popcount lanes per row
  localparam int LANES = 4;

  // Cycles spent flushing the pipeline after the last address
  localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/fp_match_popcount.sv
// fp_popcount: two-stage WIDTH-bit population count with a valid flag.
// Stage 1 registers LANES partial counts; stage 2 sums them, and the sum is
// registered by the consumer (the accumulator) in the following cycle.
module fp_popcount
  import fp_match_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  output logic [CW-1:0]    count
);

  localparam int LW = WIDTH / LANES;
  localparam int PW = $clog2(LW + 1);

  logic [PW-1:0] part_s [LANES];
  logic [PW-1:0] part_r [LANES];

  // Per-lane bit counts of the incoming row
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      part_s[l] = '0;
      for (int b = 0; b < LW; b++) begin
        part_s[l] = part_s[l] + PW'(in_bits[l*LW + b]);
      end
    end
  end

  // Stage 1: register partial counts and the valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        part_r[l] <= '0;
      end
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int l = 0; l < LANES; l++) begin
          part_r[l] <= part_s[l];
        end
      end
    end
  end

  // Stage 2: add the registered partials into the row count
  always_comb begin
    count = '0;
    for (int l = 0; l < LANES; l++) begin
      count = count + CW'(part_r[l]);
    end
  end

endmodule

// File: rtl/fp_match.sv
// fp_match: fingerprint search engine. Walks the store's search ports over
// every vertical offset in [-OFFSET_MAX, +OFFSET_MAX], scores ridge overlap
// per offset and reports the best score, its offset and a threshold match.
// Optional feature macro: FP_MATCH_XNOR_EN (score equal bits instead of overlap).
module fp_match
  import fp_match_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int OFFSET_MAX = OFFSET_MAX_DEF,
  parameter int SW         = $clog2(ROWS * WIDTH + 1),
  parameter int OW         = $clog2(OFFSET_MAX + 1) + 1
) (
  input  logic                 search_clk,
  input  logic                 search_rst,
  input  logic                 start,
  input  logic [SW-1:0]        threshold,
  output logic [AW-1:0]        search_out_add,
  output logic [AW-1:0]        search_out_add_test,
  input  logic [2*WIDTH-1:0]   search_out_data,
  output logic                 busy,
  output logic                 done,
  output logic [SW-1:0]        best_score,
  output logic signed [OW-1:0] best_offset,
  output logic                 match
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = AW + 2;
  localparam int DW = $clog2(DRAIN_CYCLES);

  state_t                state_r;
  logic [DW-1:0]         drain_r;
  logic [SW-1:0]         thr_r;

  // Issue stage: currently addressed row/offset
  logic [AW-1:0]         row_r;
  logic signed [OW-1:0]  off_r;
  logic                  a_act;
  logic                  a_inr;

  logic [AW-1:0]         nxt_row;
  logic signed [OW-1:0]  nxt_off;
  logic signed [IW-1:0]  test_idx;
  logic                  nxt_inr;
  logic                  start_s;
  logic                  last_s;
  logic                  issue_s;

  // Data stage (store word valid)
  logic                  b_act;
  logic                  b_inr;
  logic                  b_first;
  logic                  b_last;
  logic signed [OW-1:0]  b_off;
  logic [WIDTH-1:0]      tmpl_row;
  logic [WIDTH-1:0]      test_row;
  logic [WIDTH-1:0]      row_raw;
  logic [WIDTH-1:0]      row_bits;

  // Partial-count stage
  logic                  c_first;
  logic                  c_last;
  logic signed [OW-1:0]  c_off;
  logic                  pc_valid;
  logic [CW-1:0]         pc_count;

  // Accumulate stage
  logic                  d_act;
  logic                  d_last;
  logic signed [OW-1:0]  d_off;
  logic [SW-1:0]         acc;

  // Control qualifiers: accepted start, final address, and whether to issue
  always_comb begin
    start_s = (state_r == ST_IDLE) && start;
    last_s  = (row_r == AW'(ROWS - 1)) && (off_r == OW'(OFFSET_MAX));
    issue_s = start_s || ((state_r == ST_RUN) && !last_s);
  end

  // Next row/offset to issue and the corresponding test row index
  always_comb begin
    if (state_r == ST_IDLE) begin
      nxt_row = '0;
      nxt_off = OW'(-OFFSET_MAX);
    end else if (row_r == AW'(ROWS - 1)) begin
      nxt_row = '0;
      nxt_off = off_r + OW'(1);
    end else begin
      nxt_row = row_r + AW'(1);
      nxt_off = off_r;
    end
    test_idx = $signed({2'b00, nxt_row}) + IW'(nxt_off);
    nxt_inr  = !test_idx[IW-1] && (test_idx[IW-2:0] < (IW-1)'(ROWS));
  end

  // Search controller: state, busy/done and threshold capture
  always_ff @(posedge search_clk) begin
    if (search_rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      drain_r <= '0;
      thr_r   <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
            thr_r   <= threshold;
          end
        end
        ST_RUN: begin
          if (last_s) begin
            state_r <= ST_DRAIN;
            drain_r <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_r == DW'(DRAIN_CYCLES - 1)) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_r <= drain_r + DW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Address issue: one registered address pair per cycle while searching
  always_ff @(posedge search_clk) begin
    if (search_rst) begin
      row_r               <= '0;
      off_r               <= OW'(-OFFSET_MAX);
      search_out_add      <= '0;
      search_out_add_test <= '0;
      a_act               <= 1'b0;
      a_inr               <= 1'b0;
    end else begin
      a_act <= issue_s;
      if (issue_s) begin
        row_r               <= nxt_row;
        off_r               <= nxt_off;
        a_inr               <= nxt_inr;
        search_out_add      <= nxt_row;
        search_out_add_test <= nxt_inr ? test_idx[AW-1:0] : '0;
      end
    end
  end

  // Row combine; out-of-range test rows contribute nothing
  always_comb begin
    tmpl_row = search_out_data[TMPL_FIELD*WIDTH +: WIDTH];
    test_row = search_out_data[TEST_FIELD*WIDTH +: WIDTH];
`ifdef FP_MATCH_XNOR_EN
    row_raw  = ~(tmpl_row ^ test_row);
`else
    row_raw  = tmpl_row & test_row;
`endif
    if (b_inr) begin
      row_bits = row_raw;
    end else begin
      row_bits = '0;
    end
  end

  fp_popcount #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_popcount (
    .clk       (search_clk),
    .rst       (search_rst),
    .in_valid  (b_act),
    .in_bits   (row_bits),
    .out_valid (pc_valid),
    .count     (pc_count)
  );

  // Row tags follow the data down the pipeline; acc restarts at row 0
  always_ff @(posedge search_clk) begin
    if (search_rst) begin
      b_act   <= 1'b0;
      b_inr   <= 1'b0;
      b_first <= 1'b0;
      b_last  <= 1'b0;
      b_off   <= '0;
      c_first <= 1'b0;
      c_last  <= 1'b0;
      c_off   <= '0;
      d_act   <= 1'b0;
      d_last  <= 1'b0;
      d_off   <= '0;
      acc     <= '0;
    end else begin
      b_act   <= a_act;
      b_inr   <= a_inr;
      b_first <= (row_r == AW'(0));
      b_last  <= (row_r == AW'(ROWS - 1));
      b_off   <= off_r;
      c_first <= b_first;
      c_last  <= b_last;
      c_off   <= b_off;
      d_act   <= pc_valid;
      d_last  <= c_last;
      d_off   <= c_off;
      if (pc_valid) begin
        acc <= (c_first ? SW'(0) : acc) + SW'(pc_count);
      end
    end
  end

  // Best-offset tracking; ties keep the earlier (more negative) offset
  always_ff @(posedge search_clk) begin
    if (search_rst || start_s) begin
      best_score  <= '0;
      best_offset <= OW'(-OFFSET_MAX);
      match       <= 1'b0;
    end else if (d_act && d_last) begin
      if (acc > best_score) begin
        best_score  <= acc;
        best_offset <= d_off;
        match       <= (acc >= thr_r);
      end else begin
        match       <= (best_score >= thr_r);
      end
    end
  end

endmodule

// File: tb/tb_fp_match.sv
// tb_fp_match: self-checking bench for fp_match with a 1-cycle store model
// and a behavioural per-offset scoring model. Honours FP_MATCH_XNOR_EN.
module tb_fp_match;

  localparam int ROWS = 256;
  localparam int W    = 256;
  localparam int OM   = 8;
  localparam int LAT  = (2*OM + 1)*ROWS + 4;

  logic                search_clk;
  logic                search_rst;
  logic                start;
  logic [16:0]         threshold;
  logic [7:0]          search_out_add;
  logic [7:0]          search_out_add_test;
  logic [2*W-1:0]      search_out_data;
  logic                busy;
  logic                done;
  logic [16:0]         best_score;
  logic signed [4:0]   best_offset;
  logic                match;

  logic [W-1:0] tmpl_mem [ROWS];
  logic [W-1:0] test_mem [ROWS];

  int checks   = 0;
  int failures = 0;

  fp_match dut (
    .search_clk          (search_clk),
    .search_rst          (search_rst),
    .start               (start),
    .threshold           (threshold),
    .search_out_add      (search_out_add),
    .search_out_add_test (search_out_add_test),
    .search_out_data     (search_out_data),
    .busy                (busy),
    .done                (done),
    .best_score          (best_score),
    .best_offset         (best_offset),
    .match               (match)
  );

  initial begin
    search_clk = 1'b0;
    forever #5 search_clk = ~search_clk;
  end

  // Store model: registered read, one cycle after the address
  always @(posedge search_clk) begin
    search_out_data <= {tmpl_mem[search_out_add], test_mem[search_out_add_test]};
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic longint row_score(input logic [W-1:0] t, input logic [W-1:0] s);
`ifdef FP_MATCH_XNOR_EN
    return longint'($countones(~(t ^ s)));
`else
    return longint'($countones(t & s));
`endif
  endfunction

  // kind: 0 all zero, 1 all ones, 2 rows 100/103, 3 random with planted shift
  task automatic fill(input int kind);
    int k;
    k = int'($urandom_range(16, 0)) - OM;
    for (int r = 0; r < ROWS; r++) begin
      case (kind)
        0: begin tmpl_mem[r] = '0; test_mem[r] = '0; end
        1: begin tmpl_mem[r] = '1; test_mem[r] = '1; end
        2: begin
          tmpl_mem[r] = (r == 100) ? '1 : '0;
          test_mem[r] = (r == 103) ? '1 : '0;
        end
        default: begin
          tmpl_mem[r] = rnd_row() & rnd_row();
          test_mem[r] = rnd_row() & rnd_row() & rnd_row();
        end
      endcase
    end
    if (kind == 3) begin
      for (int r = 0; r < ROWS; r++)
        if (r + k >= 0 && r + k < ROWS) test_mem[r + k] = tmpl_mem[r];
    end
  endtask

  // Best score over all offsets; strictly greater wins, ties keep earlier
  task automatic model(output longint eb, output longint eo);
    longint s;
    eb = 0;
    eo = -OM;
    for (int o = -OM; o <= OM; o++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++)
        if (r + o >= 0 && r + o < ROWS) s += row_score(tmpl_mem[r], test_mem[r + o]);
      if (s > eb) begin eb = s; eo = o; end
    end
  endtask

  // Called in cycle 1 of a search; returns the cycle done was seen (-1 if never)
  task automatic wait_done(output int dc);
    int c;
    c  = 1;
    dc = -1;
    while (dc < 0 && c <= LAT + 1000) begin
      if (done === 1'b1) dc = c;
      else begin @(posedge search_clk); #1; c++; end
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_best_score"}, best_score, 0);
    check({tag, "_best_offset"}, $signed(best_offset), -OM);
    check({tag, "_add"}, search_out_add, 0);
    check({tag, "_add_test"}, search_out_add_test, 0);
  endtask

  task automatic run_check(input string tag, input logic [16:0] thr, input longint eb,
                           input longint eo, input logic em);
    int dc;
    threshold = thr;
    start     = 1'b1;
    @(posedge search_clk); #1;
    start     = 1'b0;
    threshold = ~thr;
    check({tag, "_busy_c1"}, busy, 1);
    wait_done(dc);
    check({tag, "_done_cycle"}, dc, LAT);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_best_score"}, best_score, eb);
    check({tag, "_best_offset"}, $signed(best_offset), eo);
    check({tag, "_match"}, match, em);
    @(posedge search_clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold_score"}, best_score, eb);
  endtask

  initial begin
    longint eb, eo;
    int     ndone, dcyc, dc;
    logic [16:0] thr;

    search_rst = 1'b1;
    start      = 1'b0;
    threshold  = '0;
    fill(0);
    repeat (3) @(posedge search_clk);
    #1;
    chk_reset("rst");
    search_rst = 1'b0;
    @(posedge search_clk); #1;

    // All-ones prints: peak at offset 0 with every bit counted
    fill(1);
    run_check("ones", 17'd40000, 65536, 0, 1'b1);

    // All-zero prints
    fill(0);
    model(eb, eo);
    run_check("zeros", 17'd1, eb, eo, eb >= 1);

    // Single ridge row, template 100 vs test 103
    fill(2);
    model(eb, eo);
    run_check("row100", 17'd256, eb, eo, eb >= 256);

    // Random prints with a planted shift, threshold exactly at and above best
    fill(3);
    model(eb, eo);
    thr = 17'(eb);
    run_check("rnd_eq", thr, eb, eo, 1'b1);
    thr = 17'(eb + 1);
    run_check("rnd_gt", thr, eb, eo, 1'b0);

    // Reset in the middle of an all-ones search, then a clean restart
    fill(1);
    threshold = 17'd40000;
    start     = 1'b1;
    @(posedge search_clk); #1;
    start     = 1'b0;
    repeat (999) @(posedge search_clk);
    #1;
    search_rst = 1'b1;
    @(posedge search_clk); #1;
    chk_reset("midrst");
    search_rst = 1'b0;
    @(posedge search_clk); #1;
    run_check("after_rst", 17'd40000, 65536, 0, 1'b1);

    // Extra starts while busy or in the done cycle are ignored
    fill(3);
    model(eb, eo);
    thr       = 17'(eb / 2);
    threshold = thr;
    start     = 1'b1;
    @(posedge search_clk); #1;
    ndone = 0;
    dcyc  = -1;
    for (int c = 1; c <= LAT + 1; c++) begin
      if (done === 1'b1) begin
        ndone++;
        dcyc = c;
        check("ms_best_score", best_score, eb);
        check("ms_best_offset", $signed(best_offset), eo);
        check("ms_match", match, 1);
      end
      if (c == LAT + 1) check("ms_busy_done_start_ignored", busy, 0);
      start = (c == 50 || c == 4000 || c == LAT || c == LAT + 1);
      @(posedge search_clk); #1;
    end
    start = 1'b0;
    check("ms_done_count", ndone, 1);
    check("ms_done_cycle", dcyc, LAT);
    check("ms_restart_busy", busy, 1);
    wait_done(dc);
    check("ms_second_done_cycle", dc, LAT);
    check("ms_second_best_score", best_score, eb);
    check("ms_second_best_offset", $signed(best_offset), eo);
    @(posedge search_clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
